// File: rtl/qdec_pkg.sv
// Shared types and transition decode for the quadrature decoder.
package qdec_pkg;

   typedef logic [1:0] qstate_t;

   localparam qstate_t Q00 = 2'b00;
   localparam qstate_t Q10 = 2'b10;
   localparam qstate_t Q11 = 2'b11;
   localparam qstate_t Q01 = 2'b01;

   // Returns {valid, up, illegal}; the up order is 00->10->11->01->00 (A leads B).
   function automatic logic [2:0] qdec_step(qstate_t prev, qstate_t next);
      qstate_t succ;
      succ = Q00;
      case (prev)
         Q00:     succ = Q10;
         Q10:     succ = Q11;
         Q11:     succ = Q01;
         default: succ = Q00;
      endcase
      if (prev == next)
         return 3'b000;
      else if ((prev ^ next) == 2'b11)
         return 3'b001;
      else if (next == succ)
         return 3'b110;
      else
         return 3'b100;
   endfunction

endpackage

// File: rtl/quad_decoder_filter.sv
// Thin wrapper kept for codebase layout; the filter itself is qdec_filter below.
module quad_decoder_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic vld
);

   qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (q),
      .vld (vld)
   );

endmodule

// One-bit synchroniser plus stability filter: q takes the synced value once it
// has been seen on FILT_LEN consecutive cycles; vld rises on the first accept.
module qdec_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic vld
);

   localparam int CW = $clog2(FILT_LEN + 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   sprev;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          run;

   assign s = sync[SYNC_STAGES-1];

   // run = length of the current constant stretch of s, saturating at FILT_LEN
   always_comb begin
      run = CW'(1);
      if (s == sprev)
         run = (cnt == CW'(FILT_LEN)) ? cnt : cnt + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= '0;
         sprev <= 1'b0;
         cnt   <= '0;
         q     <= 1'b0;
         vld   <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], d};
         sprev <= s;
         cnt   <= run;
         if (run == CW'(FILT_LEN)) begin
            q   <= s;
            vld <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered qa/qb -> wrapping up/down position count.
// Optional index reset of pos enabled with `define QDEC_INDEX_EN.
module quad_decoder
   import qdec_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             qa,
   input  logic             qb,
   input  logic             en,
   input  logic             clr,
   input  logic             err_clr,
`ifdef QDEC_INDEX_EN
   input  logic             idx,
`endif
   output logic [CNT_W-1:0] pos,
   output logic             dir,
   output logic             step,
   output logic             err
);

   logic    qa_f, qa_v, qb_f, qb_v;
   logic    st_vld;
   qstate_t cur, st;
   logic    init;
   logic [2:0] dec;
   logic    dv, dup, dill;
   logic    step_now;
   logic    idx_load;

   qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fa (
      .clk(clk), .rst(rst), .d(qa), .q(qa_f), .vld(qa_v)
   );
   qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fb (
      .clk(clk), .rst(rst), .d(qb), .q(qb_f), .vld(qb_v)
   );

   assign cur    = {qa_f, qb_f};
   assign st_vld = qa_v & qb_v;
   assign dec    = qdec_step(st, cur);
   assign dv     = dec[2];
   assign dup    = dec[1];
   assign dill   = dec[0];
   // S keeps tracking with en low; only the count side is gated.
   assign step_now = !init && dv && en;

`ifdef QDEC_INDEX_EN
   logic idx_f, idx_v, idx_q;

   qdec_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fi (
      .clk(clk), .rst(rst), .d(idx), .q(idx_f), .vld(idx_v)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idx_q <= 1'b0;
      else     idx_q <= idx_f;
   end

   assign idx_load = !init && idx_v && idx_f && !idx_q && (st == Q00);
`else
   assign idx_load = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st   <= Q00;
         init <= 1'b1;
         pos  <= '0;
         dir  <= 1'b0;
         step <= 1'b0;
         err  <= 1'b0;
      end else begin
         step <= step_now;
         // first accepted state after reset is only loaded, never decoded
         if (init) begin
            if (st_vld) begin
               st   <= cur;
               init <= 1'b0;
            end
         end else begin
            st <= cur;
         end
         if (step_now)
            dir <= dup;
         if (clr)
            pos <= '0;
         else if (idx_load)
            pos <= '0;
         else if (step_now)
            pos <= dup ? pos + CNT_W'(1) : pos - CNT_W'(1);
         if (!init && dill)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: step scoreboard plus per-scenario checks.
module tb_quad_decoder;

   localparam int LAT = 6;

   logic        clk = 1'b0;
   logic        rst, qa, qb, en, clr, err_clr;
`ifdef QDEC_INDEX_EN
   logic        idx;
`endif
   logic [15:0] pos;
   logic        dir, step, err;

   typedef struct {
      logic [15:0] pos;
      logic        dir;
      int          due;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          steps_seen = 0;
   logic [15:0] m_pos;
   logic        m_dir;
   logic [1:0]  m_s;

   quad_decoder dut (
      .clk     (clk),
      .rst     (rst),
      .qa      (qa),
      .qb      (qb),
      .en      (en),
      .clr     (clr),
      .err_clr (err_clr),
`ifdef QDEC_INDEX_EN
      .idx     (idx),
`endif
      .pos     (pos),
      .dir     (dir),
      .step    (step),
      .err     (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard consumer: every step pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && step === 1'b1) begin
         steps_seen++;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_step cyc=%0d pos=%h dir=%b", cyc, pos, dir);
         end else begin
            mon_e = sb.pop_front();
            if (pos !== mon_e.pos || dir !== mon_e.dir || cyc != mon_e.due) begin
               fails++;
               $display("FAIL step_pulse got pos=%h dir=%b cyc=%0d want pos=%h dir=%b cyc=%0d",
                        pos, dir, cyc, mon_e.pos, mon_e.dir, mon_e.due);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [1:0] nxt_up(logic [1:0] s);
      case (s)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] nxt_dn(logic [1:0] s);
      case (s)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a new phase state; legal counted moves push their expected step.
   task automatic move(input logic [1:0] ns, input int hold, input bit clr_at_step);
      logic up, legal;
      up    = (ns == nxt_up(m_s));
      legal = (ns != m_s) && ((ns ^ m_s) != 2'b11);
      {qa, qb} = ns;
      if (legal && en) begin
         m_pos = clr_at_step ? 16'h0 : (up ? m_pos + 16'h1 : m_pos - 16'h1);
         m_dir = up;
         sb.push_back('{m_pos, m_dir, cyc + LAT});
      end
      m_s = ns;
      if (clr_at_step) begin
         repeat (LAT - 1) tick();
         clr = 1'b1;
         tick();
         clr = 1'b0;
         repeat (hold - LAT) tick();
      end else begin
         repeat (hold) tick();
      end
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      m_pos = 16'h0;
   endtask

   task automatic test_reset();
      int s0;
      rst = 1'b1; qa = 1'b0; qb = 1'b0; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
`ifdef QDEC_INDEX_EN
      idx = 1'b0;
`endif
      repeat (3) tick();
      tests++;
      if (pos !== 16'h0 || dir !== 1'b0 || step !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_values got pos=%h dir=%b step=%b err=%b want 0", pos, dir, step, err);
      end
      rst = 1'b0; m_pos = 16'h0; m_dir = 1'b0; m_s = 2'b00;
      s0 = steps_seen;
      repeat (10) tick();
      tests++;
      if (pos !== 16'h0 || err !== 1'b0 || steps_seen != s0) begin
         fails++;
         $display("FAIL idle_after_reset got pos=%h err=%b steps=%0d want 0 0 0", pos, err, steps_seen - s0);
      end
   endtask

   task automatic test_up();
      int s0;
      s0 = steps_seen;
      for (int i = 0; i < 8; i++) move(nxt_up(m_s), 20, 1'b0);
      tests++;
      if (pos !== 16'd8 || dir !== 1'b1 || steps_seen - s0 != 8 || sb.size() != 0) begin
         fails++;
         $display("FAIL up_8 got pos=%h dir=%b steps=%0d pend=%0d want 0008 1 8 0",
                  pos, dir, steps_seen - s0, sb.size());
      end
   endtask

   task automatic test_down_wrap();
      do_clr();
      for (int i = 0; i < 3; i++) move(nxt_dn(m_s), 20, 1'b0);
      tests++;
      if (pos !== 16'hFFFD || dir !== 1'b0) begin
         fails++;
         $display("FAIL down_wrap got pos=%h dir=%b want fffd 0", pos, dir);
      end
      for (int i = 0; i < 3; i++) move(nxt_up(m_s), 20, 1'b0);
      tests++;
      if (pos !== 16'h0 || dir !== 1'b1) begin
         fails++;
         $display("FAIL up_wrap got pos=%h dir=%b want 0000 1", pos, dir);
      end
   endtask

   task automatic test_err();
      move(2'b11, 20, 1'b0);
      tests++;
      if (err !== 1'b1 || pos !== 16'h0) begin
         fails++;
         $display("FAIL illegal_jump got err=%b pos=%h want 1 0000", err, pos);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      tests++;
      if (err !== 1'b0) begin
         fails++;
         $display("FAIL err_clr got err=%b want 0", err);
      end
      move(2'b10, 20, 1'b0);
      tests++;
      if (pos !== 16'hFFFF || dir !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL step_after_err got pos=%h dir=%b err=%b want ffff 0 0", pos, dir, err);
      end
   endtask

   task automatic test_glitch();
      int s0;
      s0 = steps_seen;
      qa = ~qa;
      repeat (2) tick();
      qa = ~qa;
      repeat (20) tick();
      tests++;
      if (pos !== m_pos || steps_seen != s0 || err !== 1'b0) begin
         fails++;
         $display("FAIL glitch got pos=%h steps=%0d err=%b want %h 0 0", pos, steps_seen - s0, err, m_pos);
      end
   endtask

   task automatic test_clr_step();
      int s0;
      s0 = steps_seen;
      move(nxt_up(m_s), 20, 1'b1);
      tests++;
      if (pos !== 16'h0 || steps_seen - s0 != 1 || sb.size() != 0) begin
         fails++;
         $display("FAIL clr_with_step got pos=%h steps=%0d want 0000 1", pos, steps_seen - s0);
      end
   endtask

   task automatic test_en();
      int s0;
      logic [15:0] p0;
      do_clr();
      move(nxt_up(m_s), 20, 1'b0);
      p0 = m_pos;
      s0 = steps_seen;
      en = 1'b0;
      for (int i = 0; i < 4; i++) move(nxt_dn(m_s), 20, 1'b0);
      tests++;
      if (pos !== p0 || dir !== 1'b1 || steps_seen != s0) begin
         fails++;
         $display("FAIL en_hold got pos=%h dir=%b steps=%0d want %h 1 0", pos, dir, steps_seen - s0, p0);
      end
      move(~m_s, 20, 1'b0);
      tests++;
      if (err !== 1'b1 || pos !== p0) begin
         fails++;
         $display("FAIL en_err got err=%b pos=%h want 1 %h", err, pos, p0);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      en = 1'b1;
      move(nxt_dn(m_s), 20, 1'b0);
      tests++;
      if (pos !== p0 - 16'h1 || dir !== 1'b0) begin
         fails++;
         $display("FAIL en_resume got pos=%h dir=%b want %h 0", pos, dir, p0 - 16'h1);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) move(nxt_up(m_s), 4, 1'b0);
      repeat (10) tick();
      tests++;
      if (pos !== m_pos || sb.size() != 0) begin
         fails++;
         $display("FAIL back_to_back got pos=%h pend=%0d want %h 0", pos, sb.size(), m_pos);
      end
   endtask

   task automatic test_reset_mid();
      int s0;
      if (m_s == 2'b00) move(nxt_up(m_s), 20, 1'b0);
      move(nxt_up(m_s), 3, 1'b0);
      rst = 1'b1;
      sb.delete();
      m_pos = 16'h0;
      tick();
      tests++;
      if (pos !== 16'h0 || step !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid got pos=%h step=%b dir=%b err=%b want 0", pos, step, dir, err);
      end
      repeat (2) tick();
      rst = 1'b0;
      s0 = steps_seen;
      repeat (15) tick();
      tests++;
      if (pos !== 16'h0 || steps_seen != s0 || err !== 1'b0) begin
         fails++;
         $display("FAIL first_state_after_reset got pos=%h steps=%0d err=%b want 0", pos, steps_seen - s0, err);
      end
      move(nxt_up(m_s), 20, 1'b0);
      tests++;
      if (pos !== 16'h1 || dir !== 1'b1) begin
         fails++;
         $display("FAIL step_after_reset got pos=%h dir=%b want 0001 1", pos, dir);
      end
   endtask

`ifdef QDEC_INDEX_EN
   task automatic test_index();
      while (m_s != 2'b01) move(nxt_up(m_s), 20, 1'b0);
      do_clr();
      for (int i = 0; i < 5; i++) move(nxt_up(m_s), 20, 1'b0);
      idx = 1'b1;
      repeat (5) tick();
      idx = 1'b0;
      repeat (20) tick();
      m_pos = 16'h0;
      tests++;
      if (pos !== 16'h0) begin
         fails++;
         $display("FAIL index_at_00 got pos=%h want 0000", pos);
      end
      while (m_s != 2'b10) move(nxt_up(m_s), 20, 1'b0);
      do_clr();
      for (int i = 0; i < 5; i++) move(nxt_up(m_s), 20, 1'b0);
      idx = 1'b1;
      repeat (5) tick();
      idx = 1'b0;
      repeat (20) tick();
      tests++;
      if (pos !== 16'd5) begin
         fails++;
         $display("FAIL index_at_11 got pos=%h want 0005", pos);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_up();
      test_down_wrap();
      test_err();
      test_glitch();
      test_clr_step();
      test_en();
      test_back_to_back();
      test_reset_mid();
`ifdef QDEC_INDEX_EN
      test_index();
`endif
      repeat (10) tick();
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got pend=%0d want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
